// File: rtl/real_sampler_if.sv
// Consumer-side handshake bundle for real_sampler: FIFO head code, occupancy and valid/ready.
// An entry transfers on a rising clk edge where valid && ready. valid never waits on ready, and ready may
// be high while valid is low, which has no effect. code is stable while valid is high and not popped.
interface real_sampler_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic signed [WIDTH-1:0] code;
  logic                    valid;
  logic                    ready;
  logic [CW-1:0]           count;

  modport master (
    output code,
    output valid,
    output count,
    input  ready
  );

  modport slave (
    input  code,
    input  valid,
    input  count,
    output ready
  );
endinterface

// File: rtl/real_sampler.sv
// Samples a real input on enabled clock edges, scales/rounds/saturates it to a signed code,
// and buffers the codes in a small FIFO read through a valid/ready handshake.
module real_sampler #(
  parameter real scale  = 1.0,
  parameter real lsb    = 0.01,
  parameter real offset = 0.0,
  parameter int  WIDTH  = 8,
  parameter int  DEPTH  = 4
) (
  input  logic clk,
  input  logic rstb,
  input  logic en,
  input  real  in,
  input  logic clr_flags,
  output logic ovf,
  output logic drop,
  real_sampler_if.master rd
);
  localparam int     AW   = $clog2(DEPTH);
  localparam int     CW   = $clog2(DEPTH + 1);
  localparam longint MAXQ = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;
  localparam longint MINQ = -(64'sd1 <<< (WIDTH - 1));
  localparam real    MAXR = real'(MAXQ);
  localparam real    MINR = real'(MINQ);

  logic signed [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rptr;
  logic [CW-1:0]           r_count;
  logic signed [WIDTH-1:0] r_hold;
  logic                    r_ovf;
  logic                    r_drop;

  real                     w_x;
  real                     w_fl;
  logic signed [WIDTH-1:0] w_code;
  logic                    w_sat;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_drop_ev;

  // Clamp in the real domain so out-of-range values never reach the integer conversion.
  always_comb begin
    w_x    = (in * scale - offset) / lsb;
    w_fl   = $floor(w_x + 0.5);
    w_sat  = 1'b0;
    w_code = '0;
    if (w_fl > MAXR) begin
      w_sat  = 1'b1;
      w_code = WIDTH'(MAXQ);
    end else if (w_fl < MINR) begin
      w_sat  = 1'b1;
      w_code = WIDTH'(MINQ);
    end else begin
      w_code = WIDTH'($rtoi(w_fl));
    end
  end

  // A pop on the same edge frees the slot, so a full FIFO still accepts a push.
  always_comb begin
    w_empty   = (r_count == '0);
    w_full    = (r_count == CW'(DEPTH));
    w_pop     = !w_empty && rd.ready;
    w_push    = en && (!w_full || w_pop);
    w_drop_ev = en && w_full && !w_pop;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_hold  <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_code;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Tracks the visible head so code keeps its last value once the FIFO drains.
      if (!w_empty) begin
        r_hold <= r_mem[r_rptr];
      end
      if (w_push && w_sat) begin
        r_ovf <= 1'b1;
      end else if (clr_flags) begin
        r_ovf <= 1'b0;
      end
      if (w_drop_ev) begin
        r_drop <= 1'b1;
      end else if (clr_flags) begin
        r_drop <= 1'b0;
      end
    end
  end

  assign rd.valid = (r_count != '0);
  assign rd.count = r_count;
  assign rd.code  = (r_count != '0) ? r_mem[r_rptr] : r_hold;
  assign ovf      = r_ovf;
  assign drop     = r_drop;
endmodule

// File: tb/tb_real_sampler.sv
// Self-checking bench for real_sampler: directed scenarios plus random traffic against a queue model.
module tb_real_sampler;
  localparam int W = 8;
  localparam int D = 4;

  logic clk;
  logic rstb;
  logic en;
  real  in_v;
  logic clr;
  logic ovf;
  logic drop;

  logic en2;
  real  in2_v;
  logic clr2;
  logic ovf2;
  logic drop2;

  int n_cmp;
  int n_err;

  logic signed [W-1:0] exp_q[$];
  logic signed [W-1:0] m_last;
  bit                  m_ovf;
  bit                  m_drop;

  real_sampler_if #(.WIDTH(W), .DEPTH(D)) rd_if ();
  real_sampler_if #(.WIDTH(W), .DEPTH(D)) rd2_if ();

  real_sampler #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rstb(rstb), .en(en), .in(in_v), .clr_flags(clr),
    .ovf(ovf), .drop(drop), .rd(rd_if)
  );

  real_sampler #(.scale(2.0), .offset(0.5), .lsb(0.1), .WIDTH(W), .DEPTH(D)) dut2 (
    .clk(clk), .rstb(rstb), .en(en2), .in(in2_v), .clr_flags(clr2),
    .ovf(ovf2), .drop(drop2), .rd(rd2_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void ref_quant(input real v, output int q, output bit sat);
    real x;
    real f;
    int  hi;
    int  lo;
    x   = v / 0.01;
    f   = $floor(x + 0.5);
    hi  = (1 << (W - 1)) - 1;
    lo  = -(1 << (W - 1));
    sat = 1'b0;
    if (f > real'(hi)) begin
      q = hi; sat = 1'b1;
    end else if (f < real'(lo)) begin
      q = lo; sat = 1'b1;
    end else begin
      q = $rtoi(f);
    end
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_last = '0;
    m_ovf  = 1'b0;
    m_drop = 1'b0;
  endtask

  // One clock edge of the behavioural model, using the inputs held across that edge.
  task automatic model_step();
    int  q;
    bit  sat;
    bit  pop;
    bit  full;
    bit  push;
    ref_quant(in_v, q, sat);
    pop  = (exp_q.size() != 0) && rd_if.ready;
    full = (exp_q.size() == D);
    push = en && (!full || pop);
    if (pop) m_last = exp_q.pop_front();
    if (push) exp_q.push_back(W'(q));
    if (push && sat) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (en && full && !pop) m_drop = 1'b1;
    else if (clr) m_drop = 1'b0;
  endtask

  task automatic compare_all();
    int exp_code;
    exp_code = (exp_q.size() != 0) ? int'(exp_q[0]) : int'(m_last);
    check("valid", int'(rd_if.valid), int'(exp_q.size() != 0));
    check("count", int'(rd_if.count), exp_q.size());
    check("code", int'(rd_if.code), exp_code);
    check("ovf", int'(ovf), int'(m_ovf));
    check("drop", int'(drop), int'(m_drop));
  endtask

  // driver: one rising edge, then model update and compare on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstb = 1'b0; en = 1'b0; in_v = 0.0; clr = 1'b0; rd_if.ready = 1'b0;
    en2 = 1'b0; in2_v = 0.0; clr2 = 1'b0; rd2_if.ready = 1'b1;
    model_reset();
    #12;
    check("rst_valid", int'(rd_if.valid), 0);
    check("rst_count", int'(rd_if.count), 0);
    check("rst_code", int'(rd_if.code), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_drop", int'(drop), 0);
    @(negedge clk);
    rstb = 1'b1;

    // rounding
    rd_if.ready = 1'b1; en = 1'b1;
    in_v = 0.123;  tick(); check("round_0p123", int'(rd_if.code), 12);
    check("round_valid", int'(rd_if.valid), 1);
    in_v = 0.125;  tick(); check("round_0p125", int'(rd_if.code), 13);
    in_v = -0.125; tick(); check("round_m0p125", int'(rd_if.code), -12);
    en = 1'b0;     tick(); check("hold_code", int'(rd_if.code), -12);

    // saturation and sticky ovf
    en = 1'b1; in_v = 2.0;  tick(); check("sat_pos", int'(rd_if.code), 127);
    check("sat_ovf", int'(ovf), 1);
    in_v = -2.0; tick(); check("sat_neg", int'(rd_if.code), -128);
    en = 1'b0; clr = 1'b1; tick(); check("clr_ovf", int'(ovf), 0);
    en = 1'b1; in_v = 2.0; tick(); check("set_beats_clr", int'(ovf), 1);
    en = 1'b0; clr = 1'b0; tick();

    // fill past full with ready low
    rd_if.ready = 1'b0; en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_v = k / 100.0;
      tick();
    end
    check("full_count", int'(rd_if.count), 4);
    check("full_drop", int'(drop), 1);
    en = 1'b0; rd_if.ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("drain_order", int'(rd_if.code), k);
      tick();
    end
    check("drain_empty", int'(rd_if.valid), 0);
    rd_if.ready = 1'b0; clr = 1'b1; tick(); check("clr_drop", int'(drop), 0);
    clr = 1'b0;

    // simultaneous push/pop while full
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_v = $urandom_range(0, 100) / 100.0;
      tick();
    end
    rd_if.ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_v = $urandom_range(0, 100) / 100.0;
      tick();
      check("pp_full_count", int'(rd_if.count), 4);
      check("pp_full_drop", int'(drop), 0);
    end

    // random traffic
    for (int k = 0; k < 400; k++) begin
      en          = ($urandom_range(0, 3) != 0);
      rd_if.ready = ($urandom_range(0, 2) != 0);
      clr         = ($urandom_range(0, 15) == 0);
      in_v        = (real'($urandom_range(0, 300000)) - 150000.0) / 100000.0;
      tick();
    end
    clr = 1'b0;

    // reset mid-stream, asserted between edges
    en = 1'b1; rd_if.ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_v = k * 0.2;
      tick();
    end
    en = 1'b0;
    #1 rstb = 1'b0;
    #1;
    check("mid_rst_valid", int'(rd_if.valid), 0);
    check("mid_rst_count", int'(rd_if.count), 0);
    check("mid_rst_code", int'(rd_if.code), 0);
    model_reset();
    #1 rstb = 1'b1;
    en = 1'b1; in_v = 0.07;
    tick();
    check("post_rst_code", int'(rd_if.code), 7);
    check("post_rst_count", int'(rd_if.count), 1);
    en = 1'b0;

    // scale/offset instance: (0.4*2 - 0.5)/0.1 = 3
    en2 = 1'b1; in2_v = 0.4;
    tick();
    check("scale_code", int'(rd2_if.code), 3);
    check("scale_valid", int'(rd2_if.valid), 1);
    check("scale_ovf", int'(ovf2), 0);
    en2 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
